// File: rtl/pc_sequencer.sv
// Program-counter / instruction-register sequencer: fetches over a req/ack port,
// holds the word for the decoder, then applies the decoder's next-PC command.
module pc_sequencer #(
    parameter int               PC_W        = 16,
    parameter int               INST_W      = 16,
    parameter int               OFF_W       = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [PC_W-1:0]                    i_addr,
    output logic                               i_req,
    input  logic                               i_ack,
    input  logic [INST_W-1:0]                  i_data,
    output logic [INST_W-1:0]                  ir,
    output logic                               ir_valid,
    input  logic                               exec_done,
    input  logic [2:0]                         cmd,
    input  logic                               cond,
    output logic [PC_W-1:0]                    pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_err,
    output logic [1:0]                         o_dbg_state
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [2:0] CMD_BR   = 3'b001;
    localparam logic [2:0] CMD_BRC  = 3'b010;
    localparam logic [2:0] CMD_CALL = 3'b011;
    localparam logic [2:0] CMD_RET  = 3'b100;
    localparam logic [2:0] CMD_CLR  = 3'b101;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [INST_W-1:0]   r_ir;
    logic [SP_W-1:0]     r_sp;
    logic [PC_W-1:0]     r_stack [STACK_DEPTH];

    logic [PC_W-1:0]     w_off;
    logic [PC_W-1:0]     w_tgt;
    logic                w_full;
    logic                w_empty;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_pop_idx;
    logic                w_exec_fire;

    // Handshakes: a fetch completes in any FETCH cycle where i_ack is high (i_req
    // may be acked in the same cycle it rises); an instruction retires in any EXEC
    // cycle where exec_done is high, with cmd/cond sampled on that same edge.
    // Each strobe is ignored outside its own state.
    assign w_off       = PC_W'($signed(r_ir[OFF_W-1:0]));
    // pc already points past the branch, so subtract one to be relative to it.
    assign w_tgt       = r_pc + w_off - PC_W'(1);
    assign w_full      = (r_sp == SP_FULL);
    assign w_empty     = (r_sp == '0);
    assign w_push_idx  = r_sp[IDX_W-1:0];
    assign w_pop_idx   = IDX_W'(r_sp - SP_W'(1));
    assign w_exec_fire = (r_state == S_EXEC) && exec_done;

    assign i_addr      = r_pc;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign sp          = r_sp;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (i_ack) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if ((cmd == CMD_CALL && w_full) || (cmd == CMD_RET && w_empty)) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            default: w_next_state = S_ERR;
        endcase
    end

    always_comb begin
        i_req     = 1'b0;
        ir_valid  = 1'b0;
        stack_err = 1'b0;
        case (r_state)
            S_FETCH: i_req     = 1'b1;
            S_EXEC:  ir_valid  = 1'b1;
            default: stack_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VEC;
            r_ir <= '0;
            r_sp <= '0;
        end else if (r_state == S_FETCH) begin
            if (i_ack) begin
                r_ir <= i_data;
                r_pc <= r_pc + PC_W'(1);
            end
        end else if (w_exec_fire) begin
            case (cmd)
                CMD_BR: r_pc <= w_tgt;
                CMD_BRC: begin
                    if (cond) begin
                        r_pc <= w_tgt;
                    end
                end
                CMD_CALL: begin
                    if (!w_full) begin
                        r_sp <= r_sp + SP_W'(1);
                        r_pc <= w_tgt;
                    end
                end
                CMD_RET: begin
                    if (!w_empty) begin
                        r_sp <= r_sp - SP_W'(1);
                        r_pc <= r_stack[w_pop_idx];
                    end
                end
                CMD_CLR: begin
                    r_pc <= RESET_VEC;
                    r_sp <= '0;
                end
                default: ;
            endcase
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (w_exec_fire && cmd == CMD_CALL && !w_full) begin
            r_stack[w_push_idx] <= r_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (default and PC_W=10/OFF_W=6/DEPTH=2) share
// stimulus; a per-instance behavioural model predicts every architectural output.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        cond = 1'b0;
    logic [15:0] i_data = '0;
    logic [2:0]  cmd = '0;

    logic [15:0] a_addr, a_ir, a_pc;
    logic        a_req, a_irv, a_err;
    logic [2:0]  a_sp;
    logic [1:0]  a_dbg;
    logic [9:0]  b_addr, b_pc;
    logic [15:0] b_ir;
    logic        b_req, b_irv, b_err;
    logic [1:0]  b_sp;
    logic [1:0]  b_dbg;

    int checks = 0;
    int failures = 0;

    // Model state, index 0 = default instance, 1 = small instance.
    int m_pc [2];
    int m_ir [2];
    int m_sp [2];
    int m_stk [2][8];
    bit m_exec [2];
    bit m_err [2];

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk(clk), .rst(rst), .i_addr(a_addr), .i_req(a_req), .i_ack(i_ack),
        .i_data(i_data), .ir(a_ir), .ir_valid(a_irv), .exec_done(exec_done),
        .cmd(cmd), .cond(cond), .pc(a_pc), .sp(a_sp), .stack_err(a_err),
        .o_dbg_state(a_dbg)
    );

    pc_sequencer #(.PC_W(10), .INST_W(16), .OFF_W(6), .STACK_DEPTH(2), .RESET_VEC(10'd0)) dut_b (
        .clk(clk), .rst(rst), .i_addr(b_addr), .i_req(b_req), .i_ack(i_ack),
        .i_data(i_data), .ir(b_ir), .ir_valid(b_irv), .exec_done(exec_done),
        .cmd(cmd), .cond(cond), .pc(b_pc), .sp(b_sp), .stack_err(b_err),
        .o_dbg_state(b_dbg)
    );

    function automatic int pmask(input int k);
        return (k == 0) ? 32'hFFFF : 32'h3FF;
    endfunction

    function automatic int offw(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int depth(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_ir[k] = 0; m_sp[k] = 0; m_exec[k] = 0; m_err[k] = 0;
        end
    endtask

    // One clock of architectural behaviour, using the inputs present at the edge.
    task automatic model_step(input int k);
        int off;
        int tgt;
        int w;
        if (m_err[k]) return;
        if (!m_exec[k]) begin
            if (i_ack) begin
                m_ir[k] = int'(i_data);
                m_pc[k] = (m_pc[k] + 1) & pmask(k);
                m_exec[k] = 1;
            end
        end else if (exec_done) begin
            w = offw(k);
            off = m_ir[k] & ((1 << w) - 1);
            if (off >= (1 << (w - 1))) off -= (1 << w);
            tgt = (m_pc[k] + off - 1) & pmask(k);
            m_exec[k] = 0;
            case (int'(cmd))
                1: m_pc[k] = tgt;
                2: if (cond) m_pc[k] = tgt;
                3: begin
                    if (m_sp[k] == depth(k)) m_err[k] = 1;
                    else begin
                        m_stk[k][m_sp[k]] = m_pc[k];
                        m_sp[k]++;
                        m_pc[k] = tgt;
                    end
                end
                4: begin
                    if (m_sp[k] == 0) m_err[k] = 1;
                    else begin
                        m_sp[k]--;
                        m_pc[k] = m_stk[k][m_sp[k]];
                    end
                end
                5: begin
                    m_pc[k] = 0;
                    m_sp[k] = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input bit ack, input logic [15:0] data, input bit done,
                        input logic [2:0] c, input bit cd);
        i_ack = ack; i_data = data; exec_done = done; cmd = c; cond = cd;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic fetch(input logic [15:0] data);
        tick(1'b1, data, 1'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic exec(input logic [2:0] c, input bit cd);
        tick(1'($urandom), 16'($urandom), 1'b1, c, cd);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Walks the default instance to an address using chained relative branches.
    task automatic goto_addr(input int target);
        int diff;
        for (int n = 0; n < 600 && m_pc[0] != target; n++) begin
            diff = (target - m_pc[0]) & 'hFFFF;
            if (diff >= 'h8000) diff -= 'h10000;
            if (diff > 127) diff = 127;
            if (diff < -128) diff = -128;
            fetch({8'($urandom), 8'(diff)});
            exec(3'd1, 1'($urandom));
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", a_pc); end
        checks++; if (a_ir !== 16'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0000", a_ir); end
        checks++; if ({a_req, a_irv, a_err} !== 3'b100) begin failures++; $display("FAIL reset_flags req/irv/err got=%b exp=100", {a_req, a_irv, a_err}); end
        checks++; if (a_sp !== 3'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", a_sp); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_addr !== 16'(i)) begin failures++; $display("FAIL seq_addr got=%h exp=%h", a_addr, 16'(i)); end
            d = 16'($urandom);
            fetch(d);
            checks++; if (a_ir !== d || {a_req, a_irv} !== 2'b01) begin failures++; $display("FAIL seq_fetch ir=%h req/irv=%b exp ir=%h req/irv=01", a_ir, {a_req, a_irv}, d); end
            exec((i % 2 == 0) ? 3'd0 : 3'd6 + 3'(i / 2), 1'($urandom));
            checks++; if (a_ir !== d || {a_req, a_irv} !== 2'b10) begin failures++; $display("FAIL seq_exec ir=%h req/irv=%b exp ir=%h req/irv=10", a_ir, {a_req, a_irv}, d); end
        end
    endtask

    task automatic test_wait_states();
        fetch(16'($urandom));
        exec(3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
            checks++; if (a_pc !== 16'd5 || {a_req, a_irv} !== 2'b10) begin failures++; $display("FAIL wait_hold pc=%h req/irv=%b exp pc=0005 req/irv=10", a_pc, {a_req, a_irv}); end
        end
        fetch(16'hBEEF);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (a_pc !== 16'h0 || a_ir !== 16'h0 || a_irv !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h ir=%h irv=%b exp 0000 0000 0", a_pc, a_ir, a_irv); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_branches();
        goto_addr('h10);
        fetch({8'($urandom), 8'hFC});
        exec(3'd1, 1'($urandom));
        checks++; if (a_addr !== 16'h000C) begin failures++; $display("FAIL br_back got=%h exp=000C", a_addr); end
        goto_addr('h10);
        fetch({8'($urandom), 8'hFC});
        exec(3'd2, 1'b0);
        checks++; if (a_addr !== 16'h0011) begin failures++; $display("FAIL brc_not_taken got=%h exp=0011", a_addr); end
        goto_addr('h10);
        fetch({8'($urandom), 8'h05});
        exec(3'd2, 1'b1);
        checks++; if (a_addr !== 16'h0015) begin failures++; $display("FAIL brc_taken got=%h exp=0015", a_addr); end
    endtask

    task automatic test_call_return();
        goto_addr('h20);
        fetch({8'($urandom), 8'h10});
        exec(3'd3, 1'($urandom));
        checks++; if (a_pc !== 16'h0030 || a_sp !== 3'd1) begin failures++; $display("FAIL call pc=%h sp=%0d exp pc=0030 sp=1", a_pc, a_sp); end
        fetch(16'($urandom));
        exec(3'd4, 1'($urandom));
        checks++; if (a_pc !== 16'h0021 || a_sp !== 3'd0) begin failures++; $display("FAIL ret pc=%h sp=%0d exp pc=0021 sp=0", a_pc, a_sp); end
    endtask

    task automatic test_nested_calls();
        logic [15:0] ret_q[$];
        logic [15:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            ret_q.push_back(16'(m_pc[0] + 1));
            fetch(16'($urandom));
            exec(3'd3, 1'($urandom));
            checks++; if (a_sp !== 3'(i + 1) || a_pc !== 16'(m_pc[0])) begin failures++; $display("FAIL nest_call%0d pc=%h sp=%0d exp pc=%h sp=%0d", i, a_pc, a_sp, 16'(m_pc[0]), i + 1); end
        end
        for (int i = 3; i >= 0; i--) begin
            fetch(16'($urandom));
            exec(3'd4, 1'($urandom));
            exp_pc = ret_q.pop_back();
            checks++; if (a_pc !== exp_pc || a_sp !== 3'(i)) begin failures++; $display("FAIL nest_ret%0d pc=%h sp=%0d exp pc=%h sp=%0d", i, a_pc, a_sp, exp_pc, i); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            fetch(16'($urandom));
            exec(3'd3, 1'($urandom));
        end
        fetch(16'($urandom));
        exp_pc = 16'(m_pc[0]);
        exec(3'd3, 1'($urandom));
        checks++; if ({a_err, a_req, a_irv} !== 3'b100 || a_pc !== exp_pc || a_sp !== 3'd4) begin failures++; $display("FAIL overflow err/req/irv=%b pc=%h sp=%0d exp 100 pc=%h sp=4", {a_err, a_req, a_irv}, a_pc, a_sp, exp_pc); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 16'($urandom), 1'b1, 3'($urandom), 1'($urandom));
            checks++; if ({a_err, a_req, a_irv} !== 3'b100 || a_pc !== exp_pc) begin failures++; $display("FAIL err_sticky err/req/irv=%b pc=%h exp 100 pc=%h", {a_err, a_req, a_irv}, a_pc, exp_pc); end
        end
        apply_reset();
        checks++; if ({a_err, a_req} !== 2'b01 || a_sp !== 3'd0) begin failures++; $display("FAIL err_cleared err/req=%b sp=%0d exp 01 sp=0", {a_err, a_req}, a_sp); end
    endtask

    task automatic test_underflow();
        fetch(16'($urandom));
        exec(3'd4, 1'($urandom));
        checks++; if (a_err !== 1'b1 || a_req !== 1'b0 || a_pc !== 16'h0001) begin failures++; $display("FAIL underflow err=%b req=%b pc=%h exp 1 0 0001", a_err, a_req, a_pc); end
        apply_reset();
    endtask

    task automatic test_wrap_clr();
        goto_addr('hFFFF);
        fetch({8'($urandom), 8'h02});
        exec(3'd1, 1'($urandom));
        // Relative to the branch's own address: 0xFFFF + 2 wraps to 0x0001.
        checks++; if (a_pc !== 16'h0001) begin failures++; $display("FAIL wrap_br got=%h exp=0001", a_pc); end
        for (int i = 0; i < 3; i++) begin
            fetch(16'($urandom));
            exec(3'd3, 1'($urandom));
        end
        checks++; if (a_sp !== 3'd3) begin failures++; $display("FAIL clr_pre_sp got=%0d exp=3", a_sp); end
        fetch(16'($urandom));
        exec(3'd5, 1'($urandom));
        checks++; if (a_pc !== 16'h0 || a_sp !== 3'd0 || a_err !== 1'b0) begin failures++; $display("FAIL clr pc=%h sp=%0d err=%b exp 0000 0 0", a_pc, a_sp, a_err); end
        fetch(16'($urandom));
        exec(3'd4, 1'($urandom));
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL clr_then_ret err=%b exp=1", a_err); end
        apply_reset();
    endtask

    task automatic test_random_default();
        logic [15:0] e_pc, e_ir;
        logic [2:0]  e_sp;
        logic [2:0]  e_flags;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_err[0]) apply_reset();
            tick(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
                 3'($urandom), 1'($urandom));
            e_pc = 16'(m_pc[0]); e_ir = 16'(m_ir[0]); e_sp = 3'(m_sp[0]);
            e_flags = {!m_exec[0] && !m_err[0], m_exec[0] && !m_err[0], m_err[0]};
            checks++;
            if (a_pc !== e_pc || a_ir !== e_ir || a_sp !== e_sp || {a_req, a_irv, a_err} !== e_flags) begin
                failures++;
                $display("FAIL rand_a n=%0d pc=%h ir=%h sp=%0d req/irv/err=%b exp pc=%h ir=%h sp=%0d req/irv/err=%b",
                         n, a_pc, a_ir, a_sp, {a_req, a_irv, a_err}, e_pc, e_ir, e_sp, e_flags);
            end
        end
    endtask

    task automatic test_small_params();
        logic [9:0]  e_pc;
        logic [15:0] e_ir;
        logic [1:0]  e_sp;
        logic [2:0]  e_flags;
        apply_reset();
        fetch({10'($urandom), 6'h3F});
        exec(3'd1, 1'($urandom));
        checks++; if (b_pc !== 10'h3FF) begin failures++; $display("FAIL small_wrap got=%h exp=3ff", b_pc); end
        for (int i = 0; i < 2; i++) begin
            fetch(16'($urandom));
            exec(3'd3, 1'($urandom));
        end
        checks++; if (b_sp !== 2'd2 || b_err !== 1'b0) begin failures++; $display("FAIL small_full sp=%0d err=%b exp 2 0", b_sp, b_err); end
        fetch(16'($urandom));
        exec(3'd3, 1'($urandom));
        checks++; if (b_err !== 1'b1 || b_req !== 1'b0 || b_sp !== 2'd2) begin failures++; $display("FAIL small_overflow err=%b req=%b sp=%0d exp 1 0 2", b_err, b_req, b_sp); end
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_err[1]) apply_reset();
            tick(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
                 3'($urandom), 1'($urandom));
            e_pc = 10'(m_pc[1]); e_ir = 16'(m_ir[1]); e_sp = 2'(m_sp[1]);
            e_flags = {!m_exec[1] && !m_err[1], m_exec[1] && !m_err[1], m_err[1]};
            checks++;
            if (b_pc !== e_pc || b_ir !== e_ir || b_sp !== e_sp || b_addr !== e_pc || {b_req, b_irv, b_err} !== e_flags) begin
                failures++;
                $display("FAIL rand_b n=%0d pc=%h ir=%h sp=%0d req/irv/err=%b exp pc=%h ir=%h sp=%0d req/irv/err=%b",
                         n, b_pc, b_ir, b_sp, {b_req, b_irv, b_err}, e_pc, e_ir, e_sp, e_flags);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_wait_states();
        test_branches();
        test_call_return();
        test_nested_calls();
        test_overflow();
        test_underflow();
        test_wrap_clr();
        test_random_default();
        test_small_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
